apu_encoder: RTL

Serial transmitter for the APU register link: accepts a 4-byte APU register image (`reg_0`..`reg_3`) over a valid/ready handshake and serializes it onto the `sck`/`sdi` pair that the chiptune decoder consumes. It sits on the host/controller side of the link, in the system-clock domain, and generates both the 300 baud bit clock and the data line. Each accepted image is sent as one packet followed by a fixed idle guard, so the decoder resynchronizes on every packet and raises its `change` strobe once per packet.

---
 rtl/apu_link_pkg.sv | 26 ++
 rtl/apu_encoder_if.sv | 15 +
 rtl/apu_encoder_baud_tick.sv | 36 +++
 rtl/apu_encoder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/apu_link_pkg.sv
// Definitions shared by both ends of the APU register link (encoder and chiptune decoder).
// Covers the FSM state encoding, framing constants and packing of the register image.
package apu_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_GAP   = 3'd4
  } apu_state_e;

  localparam int   REG_COUNT  = 4;
  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // reg_0 occupies the low byte so a plain right shift yields register order, LSB first.
  function automatic logic [8*REG_COUNT-1:0] pack_image(input logic [7:0] r0,
                                                        input logic [7:0] r1,
                                                        input logic [7:0] r2,
                                                        input logic [7:0] r3);
    return {r3, r2, r1, r0};
  endfunction

endpackage

// File: rtl/apu_encoder_if.sv
// Image handshake between the host and the APU link encoder.
// Handshake: the master holds valid and reg_0..reg_3 steady; a transfer happens on each rising clk edge where valid && ready.
interface apu_encoder_if;
  logic       valid;
  logic       ready;
  logic [7:0] reg_0;
  logic [7:0] reg_1;
  logic [7:0] reg_2;
  logic [7:0] reg_3;

  modport master (output valid, output reg_0, output reg_1, output reg_2, output reg_3,
                  input  ready);
  modport slave  (input  valid, input  reg_0, input  reg_1, input  reg_2, input  reg_3,
                  output ready);
endinterface

// File: rtl/apu_encoder_baud_tick.sv
// Free-running bit-clock divider: sck is high for the upper half of the count, and bit_stb
// marks the cycle whose closing edge wraps the count (the falling sck edge, i.e. the bit boundary).
module baud_tick #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic sck,
  output logic bit_stb
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sck     = (cnt_q >= CNT_HALF);
  assign bit_stb = (cnt_q == CNT_MAX);

endmodule

// File: rtl/apu_encoder.sv
// APU register link transmitter: takes a 4-byte image over a valid/ready handshake and
// sends it as four 8N1 bytes (LSB first), followed by an idle-high guard, on sck/sdi.
module apu_encoder
  import apu_link_pkg::*;
#(
  parameter int CLK_DIV  = 16,
  parameter int GAP_BITS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  apu_encoder_if.slave       bus,
  output logic               sck,
  output logic               sdi,
  output logic               busy,
  output apu_state_e         dbg_state
);

  localparam int            GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
  localparam logic [1:0]    BYTE_LAST = 2'(REG_COUNT - 1);

  logic bit_stb;

  baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .sck     (sck),
    .bit_stb (bit_stb)
  );

  apu_state_e      state_q, state_d;
  logic            armed_q, armed_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]     buf_q, buf_d;
  logic            ready_int;
  logic            accept;
  logic            sdi_int;

  // armed_q holds an accepted image in IDLE until the next bit boundary, so START always
  // gets a full bit period even when the accept lands on a boundary edge.
  assign ready_int = (state_q == ST_IDLE) && !armed_q;
  assign accept    = bus.valid && ready_int;

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    gap_cnt_d  = gap_cnt_q;
    buf_d      = buf_q;
    sdi_int    = STOP_BIT;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          buf_d      = pack_image(bus.reg_0, bus.reg_1, bus.reg_2, bus.reg_3);
          armed_d    = 1'b1;
          byte_idx_d = 2'd0;
          bit_cnt_d  = 3'd0;
        end else if (armed_q && bit_stb) begin
          armed_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        sdi_int = START_BIT;
        if (bit_stb) begin
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        sdi_int = buf_q[0];
        if (bit_stb) begin
          buf_d = buf_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        sdi_int = STOP_BIT;
        if (bit_stb) begin
          if (byte_idx_q == BYTE_LAST) begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = ST_START;
          end
        end
      end
      ST_GAP: begin
        if (bit_stb) begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      armed_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      gap_cnt_q  <= '0;
      buf_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      gap_cnt_q  <= gap_cnt_d;
      buf_q      <= buf_d;
    end
  end

  assign bus.ready = ready_int;
  assign busy      = !ready_int;
  assign sdi       = sdi_int;
  assign dbg_state = state_q;

endmodule
